// File: rtl/ecp_pll_ctrl.sv
// ECP5 EHXPLLL supervisor: power-up reset, lock qualification, relock on loss,
// and PHASESEL/PHASEDIR/PHASESTEP sequencing for dynamic phase shifts.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_PLL_RST    | PLL held in reset for RST_CYCLES cycles
// ST_WAIT_LOCK  | waiting for LOCK_STABLE consecutive synchronized-lock cycles
// ST_READY      | clock usable; accepts phase-step requests
// ST_SETUP      | sel/dir settling before the first PHASESTEP pulse
// ST_STEP_LO    | PHASESTEP low pulse
// ST_STEP_GAP   | PHASESTEP high gap after each pulse
module ecp_pll_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int SETUP_CYCLES = 2,
    parameter int STEP_LOW     = 4,
    parameter int STEP_GAP     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic [1:0] pll_phasesel,
    output logic       pll_phasedir,
    output logic       pll_phasestep,
    output logic       pll_phaseloadreg,
    output logic       ready,
    output logic [7:0] relock_count,
    input  logic       step_req,
    input  logic [1:0] step_sel,
    input  logic       step_dir,
    input  logic [7:0] step_count,
    output logic       step_busy,
    output logic       step_done,
    output logic       step_err
);
    localparam int MAX_A   = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int MAX_B   = (SETUP_CYCLES > STEP_LOW) ? SETUP_CYCLES : STEP_LOW;
    localparam int MAX_C   = (MAX_B > STEP_GAP) ? MAX_B : STEP_GAP;
    localparam int CNT_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // One shared cycle counter; each state compares against its own terminal count.
    localparam logic [CW-1:0] RST_TC   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_TC  = CW'(LOCK_STABLE);
    localparam logic [CW-1:0] SETUP_TC = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] LOW_TC   = CW'(STEP_LOW - 1);
    localparam logic [CW-1:0] GAP_TC   = CW'(STEP_GAP - 1);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_READY,
        ST_SETUP,
        ST_STEP_LO,
        ST_STEP_GAP
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [7:0]      rem, rem_nx;
    logic [1:0]      sel_nx;
    logic            dir_nx;
    logic            busy_nx, done_nx, err_nx;
    logic            lost;
    logic            lk_m, lk_s;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rem_nx   = rem;
        sel_nx   = pll_phasesel;
        dir_nx   = pll_phasedir;
        busy_nx  = step_busy;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        lost     = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (cnt == RST_TC) begin
                    state_nx = ST_WAIT_LOCK;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (cnt == LOCK_TC) begin
                    state_nx = ST_READY;
                    cnt_nx   = '0;
                end else if (lk_s) begin
                    cnt_nx = cnt + CW'(1);
                end else begin
                    cnt_nx = '0;
                end
            end
            ST_READY: begin
                if (!lk_s) begin
                    lost    = 1'b1;
                    err_nx  = step_busy;
                    busy_nx = 1'b0;
                end else if (step_busy) begin
                    // zero-count request: busy for one cycle, then done
                    done_nx = 1'b1;
                    busy_nx = 1'b0;
                end else if (step_req) begin
                    sel_nx  = step_sel;
                    dir_nx  = step_dir;
                    rem_nx  = step_count;
                    busy_nx = 1'b1;
                    if (step_count != 8'd0) begin
                        state_nx = ST_SETUP;
                        cnt_nx   = '0;
                    end
                end
            end
            ST_SETUP: begin
                if (!lk_s) begin
                    lost    = 1'b1;
                    err_nx  = 1'b1;
                    busy_nx = 1'b0;
                end else if (cnt == SETUP_TC) begin
                    state_nx = ST_STEP_LO;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_STEP_LO: begin
                if (!lk_s) begin
                    lost    = 1'b1;
                    err_nx  = 1'b1;
                    busy_nx = 1'b0;
                end else if (cnt == LOW_TC) begin
                    state_nx = ST_STEP_GAP;
                    cnt_nx   = '0;
                    rem_nx   = rem - 8'd1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_STEP_GAP: begin
                if (!lk_s) begin
                    lost    = 1'b1;
                    err_nx  = 1'b1;
                    busy_nx = 1'b0;
                end else if (cnt == GAP_TC) begin
                    cnt_nx = '0;
                    if (rem != 8'd0) begin
                        state_nx = ST_STEP_LO;
                    end else begin
                        state_nx = ST_READY;
                        done_nx  = 1'b1;
                        busy_nx  = 1'b0;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = ST_PLL_RST;
                cnt_nx   = '0;
            end
        endcase
        if (lost) begin
            state_nx = ST_PLL_RST;
            cnt_nx   = '0;
        end
    end

    // Outputs are registered from the next state so PHASESTEP/RST are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_m          <= 1'b0;
            lk_s          <= 1'b0;
            state         <= ST_PLL_RST;
            cnt           <= '0;
            rem           <= '0;
            pll_phasesel  <= 2'd0;
            pll_phasedir  <= 1'b0;
            pll_rst       <= 1'b1;
            pll_phasestep <= 1'b1;
            ready         <= 1'b0;
            relock_count  <= 8'd0;
            step_busy     <= 1'b0;
            step_done     <= 1'b0;
            step_err      <= 1'b0;
        end else begin
            lk_m          <= pll_locked;
            lk_s          <= lk_m;
            state         <= state_nx;
            cnt           <= cnt_nx;
            rem           <= rem_nx;
            pll_phasesel  <= sel_nx;
            pll_phasedir  <= dir_nx;
            pll_rst       <= (state_nx == ST_PLL_RST);
            pll_phasestep <= (state_nx != ST_STEP_LO);
            ready         <= (state_nx == ST_READY);
            step_busy     <= busy_nx;
            step_done     <= done_nx;
            step_err      <= err_nx;
            if (lost && relock_count != 8'hFF) begin
                relock_count <= relock_count + 8'd1;
            end
        end
    end

    assign pll_phaseloadreg = 1'b1;

endmodule

// File: tb/tb_ecp_pll_ctrl.sv
// Directed bench for ecp_pll_ctrl: bring-up timing, lock glitch, phase-step
// request table, lock loss mid-request, and relock-count saturation.
module tb_ecp_pll_ctrl;
    localparam int STEP_LOW = 4;
    localparam int STEP_GAP = 4;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       rst, pll_locked, step_req, step_dir;
    logic [1:0] step_sel;
    logic [7:0] step_count;
    logic       pll_rst, pll_phasedir, pll_phasestep, pll_phaseloadreg;
    logic [1:0] pll_phasesel;
    logic       ready, step_busy, step_done, step_err;
    logic [7:0] relock_count;

    logic       b_rst, b_locked;
    logic       b_pll_rst, b_dir, b_step, b_loadreg, b_ready, b_busy, b_done, b_err;
    logic [1:0] b_sel;
    logic [7:0] b_relock;

    ecp_pll_ctrl dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .pll_rst(pll_rst), .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir),
        .pll_phasestep(pll_phasestep), .pll_phaseloadreg(pll_phaseloadreg),
        .ready(ready), .relock_count(relock_count),
        .step_req(step_req), .step_sel(step_sel), .step_dir(step_dir),
        .step_count(step_count), .step_busy(step_busy), .step_done(step_done),
        .step_err(step_err)
    );

    // Short lock qualification so hundreds of relocks fit in a short run.
    ecp_pll_ctrl #(.LOCK_STABLE(4)) dut_b (
        .clk(clk), .rst(b_rst), .pll_locked(b_locked),
        .pll_rst(b_pll_rst), .pll_phasesel(b_sel), .pll_phasedir(b_dir),
        .pll_phasestep(b_step), .pll_phaseloadreg(b_loadreg),
        .ready(b_ready), .relock_count(b_relock),
        .step_req(1'b0), .step_sel(2'd0), .step_dir(1'b0),
        .step_count(8'd0), .step_busy(b_busy), .step_done(b_done),
        .step_err(b_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] sel;
        logic       dir;
        logic [7:0] cnt;
        int         exp_pulses;
        int         exp_busy;
    } vec_t;

    vec_t vecs[5];

    // Raise of pll_locked already done by caller; n = ticks until ready seen.
    task automatic wait_ready(input int glitch_at, input int req_until,
                              output int n, output int side);
        n = 0;
        side = 0;
        while (!ready && n < 3000) begin
            if (glitch_at >= 0 && n == glitch_at) pll_locked = 1'b0;
            else if (glitch_at >= 0 && n == glitch_at + 1) pll_locked = 1'b1;
            step_req = (n < req_until);
            tick;
            n++;
            if (pll_rst || step_busy || step_done || step_err || !pll_phasestep) side++;
        end
        step_req = 1'b0;
    endtask

    task automatic run_req(input logic [1:0] sel, input logic dir, input logic [7:0] cnt,
                           input int lose_at, input int again_at,
                           output int pulses, output int busy_cyc, output int done_n,
                           output int err_n, output int bad_lo, output int bad_gap,
                           output int bad_sel, output int first_lo, output int rise2,
                           output int done_cyc, output int err_cyc);
        logic prev;
        int   lo_run, hi_run, fin;
        pulses = 0; busy_cyc = 0; done_n = 0; err_n = 0; bad_lo = 0; bad_gap = 0;
        bad_sel = 0; first_lo = -1; rise2 = -1; done_cyc = -1; err_cyc = -1;
        prev = 1'b1; lo_run = 0; hi_run = 0; fin = -1;
        step_sel = sel; step_dir = dir; step_count = cnt; step_req = 1'b1;
        tick;
        step_req = 1'b0;
        for (int cyc = 1; cyc <= 4000; cyc++) begin
            if (step_busy) busy_cyc++;
            if (step_busy && (pll_phasesel != sel || pll_phasedir != dir)) bad_sel++;
            if (step_done) begin done_n++; done_cyc = cyc; end
            if (step_err) begin err_n++; err_cyc = cyc; end
            if (!pll_phasestep) begin
                if (prev) begin
                    pulses++;
                    if (first_lo < 0) first_lo = cyc;
                    if (pulses > 1 && hi_run != STEP_GAP) bad_gap++;
                end
                lo_run++;
            end else begin
                if (!prev) begin
                    if (lo_run != STEP_LOW && err_n == 0) bad_lo++;
                    if (pulses == 2 && rise2 < 0) rise2 = cyc;
                    lo_run = 0;
                    hi_run = 0;
                end
                hi_run++;
            end
            prev = pll_phasestep;
            if ((step_done || step_err) && fin < 0) fin = cyc;
            if (fin >= 0 && cyc >= fin + 3) break;
            if (cyc == lose_at) pll_locked = 1'b0;
            step_req = (cyc == again_at);
            tick;
        end
        step_req = 1'b0;
        if (fin < 0) chk("req_timeout", 0, 1);
    endtask

    initial begin
        int n, side;
        int pulses, busy_cyc, done_n, err_n, bad_lo, bad_gap, bad_sel;
        int first_lo, rise2, done_cyc, err_cyc;

        //           sel   dir   cnt     pulses busy (2 + cnt*8)
        vecs[0] = '{2'd2, 1'b1, 8'd3,   3,   26};
        vecs[1] = '{2'd0, 1'b0, 8'd0,   0,   1};
        vecs[2] = '{2'd1, 1'b0, 8'd1,   1,   10};
        vecs[3] = '{2'd3, 1'b1, 8'd2,   2,   18};
        vecs[4] = '{2'd1, 1'b1, 8'd255, 255, 2042};

        rst = 1'b1; b_rst = 1'b1; pll_locked = 1'b0; b_locked = 1'b0;
        step_req = 1'b0; step_sel = 2'd0; step_dir = 1'b0; step_count = 8'd0;
        repeat (3) tick;

        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_phasesel", pll_phasesel, 0);
        chk("rst_phasedir", pll_phasedir, 0);
        chk("rst_phasestep", pll_phasestep, 1);
        chk("rst_loadreg", pll_phaseloadreg, 1);
        chk("rst_ready", ready, 0);
        chk("rst_relock", relock_count, 0);
        chk("rst_busy_done_err", {step_busy, step_done, step_err}, 0);

        // Power-up: pll_rst high for 16 cycles, then 1024 + 2 (sync) + 1 to ready.
        rst = 1'b0;
        n = 0;
        while (pll_rst && n < 100) begin n++; tick; end
        chk("pwrup_pll_rst_len", n, 16);
        pll_locked = 1'b1;
        wait_ready(-1, 0, n, side);
        chk("pwrup_ready_latency", n, 1027);
        chk("pwrup_side_activity", side, 0);

        // Re-bring-up with a 1-cycle lock glitch at stability count 500 and
        // step_req held during WAIT_LOCK; 503 + 1027 cycles to ready.
        pll_locked = 1'b0;
        rst = 1'b1;
        repeat (2) tick;
        chk("rst2_ready", ready, 0);
        chk("rst2_pll_rst", pll_rst, 1);
        rst = 1'b0;
        n = 0;
        while (pll_rst && n < 100) begin n++; tick; end
        chk("rst2_pll_rst_len", n, 16);
        pll_locked = 1'b1;
        wait_ready(502, 200, n, side);
        chk("glitch_ready_latency", n, 1530);
        chk("glitch_no_rst_no_req", side, 0);

        for (int i = 0; i < 5; i++) begin
            run_req(vecs[i].sel, vecs[i].dir, vecs[i].cnt, 0,
                    (vecs[i].cnt != 8'd0) ? 5 : 0,
                    pulses, busy_cyc, done_n, err_n, bad_lo, bad_gap, bad_sel,
                    first_lo, rise2, done_cyc, err_cyc);
            chk($sformatf("v%0d_pulses", i), pulses, vecs[i].exp_pulses);
            chk($sformatf("v%0d_busy_cycles", i), busy_cyc, vecs[i].exp_busy);
            chk($sformatf("v%0d_done_count", i), done_n, 1);
            chk($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].exp_busy + 1);
            chk($sformatf("v%0d_err_count", i), err_n, 0);
            chk($sformatf("v%0d_low_width", i), bad_lo, 0);
            chk($sformatf("v%0d_gap_width", i), bad_gap, 0);
            chk($sformatf("v%0d_sel_dir_stable", i), bad_sel, 0);
            chk($sformatf("v%0d_setup_first_low", i), first_lo,
                (vecs[i].cnt != 8'd0) ? 3 : -1);
            chk($sformatf("v%0d_ready", i), ready, 1);
        end
        chk("sel_after_requests", pll_phasesel, 1);
        chk("dir_after_requests", pll_phasedir, 1);

        // Lock dropped in the cycle before the 2nd pulse: pulse cut after 2 lows.
        run_req(2'd1, 1'b0, 8'd5, 10, 0,
                pulses, busy_cyc, done_n, err_n, bad_lo, bad_gap, bad_sel,
                first_lo, rise2, done_cyc, err_cyc);
        chk("loss_pulses", pulses, 2);
        chk("loss_err_count", err_n, 1);
        chk("loss_err_cycle", err_cyc, 13);
        chk("loss_step_high_cycle", rise2, 13);
        chk("loss_done_count", done_n, 0);
        chk("loss_busy_cycles", busy_cyc, 12);
        chk("loss_ready", ready, 0);
        chk("loss_relock_count", relock_count, 1);
        n = 0;
        while (pll_rst && n < 100) begin n++; tick; end
        chk("loss_pll_rst_len", n + 3, 16);
        pll_locked = 1'b1;
        wait_ready(-1, 0, n, side);
        chk("relock_ready_latency", n, 1027);
        run_req(vecs[2].sel, vecs[2].dir, vecs[2].cnt, 0, 0,
                pulses, busy_cyc, done_n, err_n, bad_lo, bad_gap, bad_sel,
                first_lo, rise2, done_cyc, err_cyc);
        chk("post_relock_pulses", pulses, 1);
        chk("post_relock_done", done_n, 1);
        chk("post_relock_err", err_n, 0);

        // Saturation on the short-qualification instance.
        b_rst = 1'b0;
        b_locked = 1'b1;
        for (int i = 0; i < 300; i++) begin
            n = 0;
            while (!b_ready && n < 200) begin n++; tick; end
            if (!b_ready) begin
                chk("b_ready_timeout", 0, 1);
                break;
            end
            b_locked = 1'b0;
            n = 0;
            while (b_ready && n < 20) begin n++; tick; end
            b_locked = 1'b1;
            if (i == 9) chk("b_relock_after_10", b_relock, 10);
        end
        chk("b_relock_saturated", b_relock, 255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
